// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle between the I/O layer and the nibble-serial adder sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two W-bit operands one nibble per clock through a single shared 4-bit adder,
// LSB nibble first, with a registered inter-nibble carry and a start/ready/done handshake.
module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned SELW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [SELW-1:0]   nib_lsb;
    logic [3:0]        add_s;
    logic              add_co;

    assign nib_lsb = SELW'({idx_q, 2'b00});

    full_adder_4bit u_add (
        .a    (a_q[nib_lsb +: 4]),
        .b    (b_q[nib_lsb +: 4]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // Next-state and datapath update; accept is legal from IDLE and from DONE (back-to-back).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[nib_lsb +: 4] = add_s;
                carry_d             = add_co;
                idx_d               = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NIBBLES - 1)) begin
                    idx_d   = '0;
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d != S_RUN);
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder sequencer: a 4-nibble and a 1-nibble instance.
module tb_nibble_serial_adder_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the 4-nibble instance and wait (bounded) for done.
    // lat counts cycles from the accept edge to the done cycle; busy_cnt counts RUN cycles seen.
    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output int lat, output int busy_cnt);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = cin;
        tick();
        bus4.start = 1'b0;
        bus4.a     = 16'hDEAD;
        bus4.b     = 16'hBEEF;
        bus4.cin   = 1'b1;
        lat        = 1;
        busy_cnt   = 0;
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus4.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus4.ready); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus4.busy); end
        checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus4.done); end
        checks++; if ({bus4.sum, bus4.cout, bus4.overflow} !== 18'h0) begin
            errors++; $display("FAIL reset_result got sum=%h cout=%b ovf=%b want 0", bus4.sum, bus4.cout, bus4.overflow);
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        do_op4(16'h1234, 16'h4321, 1'b0, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=4", bc); end
        checks++; if (bus4.sum !== 16'h5555) begin errors++; $display("FAIL basic_sum got=%h want=5555", bus4.sum); end
        checks++; if ({bus4.cout, bus4.overflow} !== 2'b00) begin
            errors++; $display("FAIL basic_flags got cout=%b ovf=%b want 0 0", bus4.cout, bus4.overflow);
        end
        checks++; if (bus4.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done got=%b want=1", bus4.ready); end
        repeat (3) tick();
        checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", bus4.done); end
        checks++; if (bus4.sum !== 16'h5555) begin errors++; $display("FAIL basic_hold got=%h want=5555", bus4.sum); end
    endtask

    task automatic test_carry;
        int lat, bc;
        do_op4(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        checks++; if ({bus4.done, bus4.sum, bus4.cout, bus4.overflow} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL carry_ripple got done=%b sum=%h cout=%b ovf=%b want 1 0000 1 0",
                               bus4.done, bus4.sum, bus4.cout, bus4.overflow);
        end
    endtask

    task automatic test_overflow;
        int lat, bc;
        do_op4(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        checks++; if ({bus4.sum, bus4.cout, bus4.overflow} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ovf_pos got sum=%h cout=%b ovf=%b want 8000 0 1", bus4.sum, bus4.cout, bus4.overflow);
        end
        tick();
        do_op4(16'h8000, 16'h8000, 1'b0, lat, bc);
        checks++; if ({bus4.sum, bus4.cout, bus4.overflow} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_neg got sum=%h cout=%b ovf=%b want 0000 1 1", bus4.sum, bus4.cout, bus4.overflow);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus4.start = 1'b1; bus4.a = 16'h0000; bus4.b = 16'h0000; bus4.cin = 1'b1;
        tick();
        bus4.a = 16'h0F0F; bus4.b = 16'h00F1; bus4.cin = 1'b0;
        repeat (3) tick();
        checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL b2b_ignored_busy got=%b want=1", bus4.busy); end
        tick();
        checks++; if ({bus4.done, bus4.ready, bus4.sum} !== {1'b1, 1'b1, 16'h0001}) begin
            errors++; $display("FAIL b2b_first got done=%b ready=%b sum=%h want 1 1 0001", bus4.done, bus4.ready, bus4.sum);
        end
        tick();
        bus4.start = 1'b0; bus4.a = 16'hAAAA; bus4.b = 16'h5555;
        checks++; if ({bus4.busy, bus4.sum} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL b2b_accept got busy=%b sum=%h want 1 0000", bus4.busy, bus4.sum);
        end
        n = 1;
        while (!bus4.done && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_spacing got=%0d want=5", n); end
        checks++; if ({bus4.sum, bus4.cout, bus4.overflow} !== {16'h1000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_second got sum=%h cout=%b ovf=%b want 1000 0 0", bus4.sum, bus4.cout, bus4.overflow);
        end
        tick();
    endtask

    task automatic test_abort;
        logic saw_done;
        bus4.start = 1'b1; bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        checks++; if (bus4.sum !== 16'h0003) begin errors++; $display("FAIL abort_partial got=%h want=0003", bus4.sum); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({bus4.ready, bus4.busy, bus4.done, bus4.sum, bus4.cout} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL abort_state got ready=%b busy=%b done=%b sum=%h cout=%b want 1 0 0 0000 0",
                               bus4.ready, bus4.busy, bus4.done, bus4.sum, bus4.cout);
        end
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            if (bus4.done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
    endtask

    task automatic test_nibbles1;
        int lat;
        bus1.start = 1'b1; bus1.a = 4'hF; bus1.b = 4'h1; bus1.cin = 1'b1;
        tick();
        bus1.start = 1'b0; bus1.a = 4'h0; bus1.b = 4'h0; bus1.cin = 1'b0;
        checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL n1_busy got=%b want=1", bus1.busy); end
        lat = 1;
        while (!bus1.done && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL n1_latency got=%0d want=2", lat); end
        checks++; if ({bus1.sum, bus1.cout, bus1.overflow} !== {4'h1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL n1_result got sum=%h cout=%b ovf=%b want 1 1 0", bus1.sum, bus1.cout, bus1.overflow);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_nibbles1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
